// File: rtl/apb_event_accumulator.sv
// ----------------------------------------------------------------------------
// apb_event_accumulator
//
// APB completer that receives event-count write transfers from the upstream
// event-to-APB write generator and adds each one into a saturating 32-bit
// total for the addressed source (A, B or C). Reads return the decoded total.
// Every access is held for WAIT_CYCLES wait states. An address that matches
// none of the three sources completes with an error response.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   apb_psel_i          APB select
//   apb_penable_i       APB enable (access phase)
//   apb_paddr_i [31:0]  APB address, exact compare against ADDR_A/B/C
//   apb_pwrite_i        1 = write, 0 = read
//   apb_pwdata_i[31:0]  write data (event count to accumulate)
//   apb_pready_o        completer ready, high only in ACCESS once waits expire
//   apb_pslverr_o       error response for an unmapped address (completion only)
//   apb_prdata_o[31:0]  read data (completion of a read only, else 0)
//   clear_i             synchronous clear of totals, flags and transfer count
//   acc_a_o/b_o/c_o     running totals per source
//   xfer_cnt_o  [15:0]  completed mapped write transfers, wraps
//   thresh_hit_o [2:0]  sticky {C,B,A} flags: total reached THRESH
// ----------------------------------------------------------------------------
module apb_event_accumulator #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_A      = 32'habba0000,
  parameter logic [31:0] ADDR_B      = 32'hbaff0000,
  parameter logic [31:0] ADDR_C      = 32'hcafe0000,
  parameter logic [31:0] THRESH      = 32'h00000100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        apb_psel_i,
  input  logic        apb_penable_i,
  input  logic [31:0] apb_paddr_i,
  input  logic        apb_pwrite_i,
  input  logic [31:0] apb_pwdata_i,
  output logic        apb_pready_o,
  output logic        apb_pslverr_o,
  output logic [31:0] apb_prdata_o,
  input  logic        clear_i,
  output logic [31:0] acc_a_o,
  output logic [31:0] acc_b_o,
  output logic [31:0] acc_c_o,
  output logic [15:0] xfer_cnt_o,
  output logic [2:0]  thresh_hit_o
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] wait_reg, wait_next;

  logic             complete;
  logic             any_hit;
  logic [2:0]       hit;
  logic [2:0][31:0] acc_all;
  logic [2:0]       flag_all;
  logic [31:0]      rd_mux;
  logic [15:0]      xfer_cnt_reg;

  // --------------------------------------------------------------------------
  // Transfer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      wait_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  // Ready is a pure function of state and remaining wait count.
  assign apb_pready_o = (state_reg == ACCESS) && (wait_reg == 4'd0);
  assign complete     = apb_pready_o && apb_psel_i && apb_penable_i;

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    case (state_reg)
      IDLE: begin
        if (apb_psel_i) begin
          state_next = ACCESS;
          wait_next  = WAIT_INIT;
        end
      end
      ACCESS: begin
        if (!apb_psel_i) begin
          // Requester abandoned the transfer: nothing is updated.
          state_next = IDLE;
        end else if (complete) begin
          state_next = DONE;
        end else if (wait_reg != 4'd0) begin
          wait_next = wait_reg - 4'd1;
        end
      end
      DONE: begin
        // One dead cycle so a held psel can never complete the same transfer twice.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-source totals and sticky threshold flags
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_src
    localparam logic [31:0] SRC_ADDR = (gi == 0) ? ADDR_A : (gi == 1) ? ADDR_B : ADDR_C;

    logic [31:0] acc_reg;
    logic [31:0] acc_next;
    logic [32:0] sum;
    logic        flag_reg;

    assign hit[gi] = (apb_paddr_i == SRC_ADDR);

    // The carry out of the 33-bit sum means the total would exceed 32 bits.
    assign sum      = {1'b0, acc_reg} + {1'b0, apb_pwdata_i};
    assign acc_next = sum[32] ? 32'hFFFF_FFFF : sum[31:0];

    always_ff @(posedge clk) begin
      if (reset || clear_i) begin
        acc_reg <= 32'd0;
      end else if (complete && apb_pwrite_i && hit[gi]) begin
        acc_reg <= acc_next;
      end
    end

    // Flag follows the registered total, so it rises one cycle after the total.
    always_ff @(posedge clk) begin
      if (reset || clear_i) begin
        flag_reg <= 1'b0;
      end else if (acc_reg >= THRESH) begin
        flag_reg <= 1'b1;
      end
    end

    assign acc_all[gi]  = acc_reg;
    assign flag_all[gi] = flag_reg;
  end

  assign any_hit = |hit;

  // --------------------------------------------------------------------------
  // Completed-write counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      xfer_cnt_reg <= 16'd0;
    end else if (complete && apb_pwrite_i && any_hit) begin
      xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Response
  // --------------------------------------------------------------------------
  always_comb begin
    rd_mux = 32'd0;
    for (int i = 0; i < 3; i++) begin
      if (hit[i]) begin
        rd_mux = rd_mux | acc_all[i];
      end
    end
  end

  assign apb_pslverr_o = complete && !any_hit;
  assign apb_prdata_o  = (complete && !apb_pwrite_i) ? rd_mux : 32'd0;

  assign acc_a_o      = acc_all[0];
  assign acc_b_o      = acc_all[1];
  assign acc_c_o      = acc_all[2];
  assign xfer_cnt_o   = xfer_cnt_reg;
  assign thresh_hit_o = flag_all;

endmodule

// File: tb/tb_apb_event_accumulator.sv
// ----------------------------------------------------------------------------
// tb_apb_event_accumulator
//
// Directed vector table for the main scenarios, hand-written sequences for
// abort, clear and reset-in-access, then random transfers checked against a
// simple arithmetic model of the totals, counter and flags.
// ----------------------------------------------------------------------------
module tb_apb_event_accumulator;

  localparam logic [31:0] ADDR_A = 32'habba0000;
  localparam logic [31:0] ADDR_B = 32'hbaff0000;
  localparam logic [31:0] ADDR_C = 32'hcafe0000;
  localparam logic [31:0] THRESH = 32'h00000100;
  localparam int          WAITS  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite, clear;
  logic [31:0] paddr, pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [31:0] acc_a, acc_b, acc_c;
  logic [15:0] xfer_cnt;
  logic [2:0]  thresh_hit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_event_accumulator #(
    .WAIT_CYCLES(WAITS),
    .ADDR_A(ADDR_A),
    .ADDR_B(ADDR_B),
    .ADDR_C(ADDR_C),
    .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .apb_psel_i(psel),
    .apb_penable_i(penable),
    .apb_paddr_i(paddr),
    .apb_pwrite_i(pwrite),
    .apb_pwdata_i(pwdata),
    .apb_pready_o(pready),
    .apb_pslverr_o(pslverr),
    .apb_prdata_o(prdata),
    .clear_i(clear),
    .acc_a_o(acc_a),
    .acc_b_o(acc_b),
    .acc_c_o(acc_c),
    .xfer_cnt_o(xfer_cnt),
    .thresh_hit_o(thresh_hit)
  );

  // --------------------------------------------------------------------------
  // Reference model: totals as plain integers, saturated arithmetically
  // --------------------------------------------------------------------------
  logic [31:0] m_acc [3];
  int          m_cnt;
  logic [2:0]  m_flag;

  task automatic model_zero();
    for (int i = 0; i < 3; i++) m_acc[i] = 32'd0;
    m_cnt  = 0;
    m_flag = 3'b000;
  endtask

  task automatic model_apply(input logic [31:0] addr, input logic [31:0] data,
                             input logic wr, input logic clr,
                             output logic exp_err, output logic [31:0] exp_rd);
    int     idx;
    longint s;
    idx = (addr == ADDR_A) ? 0 : (addr == ADDR_B) ? 1 : (addr == ADDR_C) ? 2 : -1;
    exp_err = (idx < 0);
    exp_rd  = (!wr && idx >= 0) ? m_acc[idx] : 32'd0;
    if (clr) begin
      model_zero();
    end else if (wr && idx >= 0) begin
      s = longint'(m_acc[idx]) + longint'(data);
      m_acc[idx] = (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
      m_cnt = (m_cnt + 1) % 65536;
    end
    for (int i = 0; i < 3; i++)
      if (m_acc[i] >= THRESH) m_flag[i] = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Drives SETUP in the current cycle (call at posedge+1), then ACCESS until ready.
  task automatic apb_do(input logic [31:0] addr, input logic [31:0] data,
                        input logic wr, input logic clr,
                        output bit done, output int ws,
                        output logic err, output logic [31:0] rd);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data; clear = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    done = 1'b0; ws = 0; err = 1'b0; rd = 32'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (pready) begin
        done = 1'b1;
        err  = pslverr;
        rd   = prdata;
        if (clr) clear = 1'b1;
        break;
      end
      ws++;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; clear = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [31:0] ec, input logic [15:0] ecnt);
    chk({tag, "_acc_a"}, acc_a, ea);
    chk({tag, "_acc_b"}, acc_b, eb);
    chk({tag, "_acc_c"}, acc_c, ec);
    chk({tag, "_xfer_cnt"}, 32'(xfer_cnt), 32'(ecnt));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pready_idle"}, 32'(pready), 32'd0);
    chk({tag, "_pslverr_idle"}, 32'(pslverr), 32'd0);
    chk({tag, "_prdata_idle"}, prdata, 32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic        clr;
    logic        chain;     // issued in the DONE cycle of the previous transfer
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] ea, eb, ec;
    logic [15:0] ecnt;
    logic [2:0]  eth;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          done;
    int          ws;
    logic        err, e_err;
    logic [31:0] rd, e_rd;
    logic        nxt_chain;
    logic [31:0] a, d;
    logic        w, c;
    int          sel;

    //           addr          data           wr    clr   chain err   rd             A             B              C              cnt     th
    vt[0]  = '{ADDR_A,       32'd5,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'd5, 32'd0,         32'd0,         16'd1, 3'b000};
    vt[1]  = '{32'hdead0000, 32'd7,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'd5, 32'd0,         32'd0,         16'd1, 3'b000};
    vt[2]  = '{ADDR_B,       32'hFFFFFFF0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'd5, 32'hFFFFFFF0,  32'd0,         16'd2, 3'b010};
    vt[3]  = '{ADDR_B,       32'h20,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'd5, 32'hFFFFFFFF,  32'd0,         16'd3, 3'b010};
    vt[4]  = '{ADDR_B,       32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF,  32'd5, 32'hFFFFFFFF,  32'd0,         16'd3, 3'b010};
    vt[5]  = '{ADDR_C,       32'h100,       1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'd0, 32'd0,         32'd0,         16'd0, 3'b000};
    vt[6]  = '{ADDR_A,       32'd3,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'd3, 32'd0,         32'd0,         16'd1, 3'b000};
    vt[7]  = '{ADDR_B,       32'd2,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'd3, 32'd2,         32'd0,         16'd2, 3'b000};
    vt[8]  = '{ADDR_A,       32'd4,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'd7, 32'd2,         32'd0,         16'd3, 3'b000};
    vt[9]  = '{32'h12345678, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'd7, 32'd2,         32'd0,         16'd3, 3'b000};
    vt[10] = '{ADDR_C,       32'h100,       1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'd7, 32'd2,         32'h100,       16'd4, 3'b100};

    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; clear = 1'b0;
    paddr = 32'd0; pwdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk_state("reset", 32'd0, 32'd0, 32'd0, 16'd0);
    chk("reset_thresh", 32'(thresh_hit), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      apb_do(vt[i].addr, vt[i].data, vt[i].wr, vt[i].clr, done, ws, err, rd);
      $display("vec %0d: addr=%h data=%h wr=%0b clr=%0b -> waits=%0d err=%0b rdata=%h",
               i, vt[i].addr, vt[i].data, vt[i].wr, vt[i].clr, ws, err, rd);
      chk($sformatf("v%0d_completed", i), 32'(done), 32'd1);
      chk($sformatf("v%0d_wait_states", i), 32'(ws), vt[i].chain ? 32'(WAITS + 1) : 32'(WAITS));
      chk($sformatf("v%0d_pslverr", i), 32'(err), 32'(vt[i].exp_err));
      if (!vt[i].wr) chk($sformatf("v%0d_prdata", i), rd, vt[i].exp_rd);
      chk_state($sformatf("v%0d", i), vt[i].ea, vt[i].eb, vt[i].ec, vt[i].ecnt);
      nxt_chain = (i + 1 < NV) ? vt[i + 1].chain : 1'b0;
      if (!nxt_chain) begin
        idle();
        chk_quiet($sformatf("v%0d", i));
        chk($sformatf("v%0d_thresh", i), 32'(thresh_hit), 32'(vt[i].eth));
      end
    end

    // ---- abort after one ACCESS cycle: A=7, B=2, C=0x100, cnt=4 ----
    psel = 1'b1; penable = 1'b0; paddr = ADDR_A; pwrite = 1'b1; pwdata = 32'd9;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    chk("abort_pready_c1", 32'(pready), 32'd0);
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort_pready_c2", 32'(pready), 32'd0);
    idle();
    chk_quiet("abort");
    chk_state("abort", 32'd7, 32'd2, 32'h100, 16'd4);
    $display("abort: psel dropped after one access cycle, acc_a=%h cnt=%0d", acc_a, xfer_cnt);
    apb_do(ADDR_A, 32'd1, 1'b1, 1'b0, done, ws, err, rd);
    $display("post-abort write: waits=%0d err=%0b", ws, err);
    chk("post_abort_done", 32'(done), 32'd1);
    chk("post_abort_waits", 32'(ws), 32'(WAITS));
    idle();
    chk_state("post_abort", 32'd8, 32'd2, 32'h100, 16'd5);

    // ---- standalone clear ----
    clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    $display("clear: acc=%h/%h/%h cnt=%0d th=%b", acc_a, acc_b, acc_c, xfer_cnt, thresh_hit);
    chk_state("clear", 32'd0, 32'd0, 32'd0, 16'd0);
    chk("clear_thresh", 32'(thresh_hit), 32'd0);
    model_zero();

    // ---- random transfers against the model ----
    for (int t = 0; t < 48; t++) begin
      sel = $urandom_range(0, 3);
      a = (sel == 0) ? ADDR_A : (sel == 1) ? ADDR_B : (sel == 2) ? ADDR_C : $urandom;
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 400));
      w = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      model_apply(a, d, w, c, e_err, e_rd);
      apb_do(a, d, w, c, done, ws, err, rd);
      idle();
      $display("rnd %0d: addr=%h data=%h wr=%0b clr=%0b -> err=%0b rdata=%h acc=%h/%h/%h cnt=%0d",
               t, a, d, w, c, err, rd, acc_a, acc_b, acc_c, xfer_cnt);
      chk($sformatf("r%0d_completed", t), 32'(done), 32'd1);
      chk($sformatf("r%0d_waits", t), 32'(ws), 32'(WAITS));
      chk($sformatf("r%0d_pslverr", t), 32'(err), 32'(e_err));
      if (!w) chk($sformatf("r%0d_prdata", t), rd, e_rd);
      chk_state($sformatf("r%0d", t), m_acc[0], m_acc[1], m_acc[2], 16'(m_cnt));
      chk($sformatf("r%0d_thresh", t), 32'(thresh_hit), 32'(m_flag));
    end

    // ---- reset while ready is high in ACCESS ----
    psel = 1'b1; penable = 1'b0; paddr = ADDR_A; pwrite = 1'b1; pwdata = 32'd1;
    @(posedge clk); #1; penable = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (pready) begin
        done = 1'b1;
        break;
      end
    end
    chk("rst_access_reached_ready", 32'(done), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    $display("reset in access: pready=%0b acc_a=%h cnt=%0d", pready, acc_a, xfer_cnt);
    chk("rst_access_pready", 32'(pready), 32'd0);
    chk_state("rst_access", 32'd0, 32'd0, 32'd0, 16'd0);
    chk("rst_access_thresh", 32'(thresh_hit), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    chk_quiet("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
